// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the K=3 rate-1/2 convolutional frame path.
// Pure declarations: no logic, no latency, no flow control.
package conv_pkg;
  localparam int K = 3;
  localparam int TAIL_LEN = K - 1;
  localparam logic [K-1:0] G_A_DEF = 3'b101;
  localparam logic [K-1:0] G_B_DEF = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/conv_core.sv
// K=3 encoder state with step/clear; coded pair is combinational from the post-step window.
// Latency: c_a/c_b valid in the cycle the step is requested; no backpressure of its own.
module conv_core
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G_A = G_A_DEF,
  parameter logic [K-1:0] G_B = G_B_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic b,
  output logic c_a,
  output logic c_b
);
  // The oldest bit falls off on every step, so only K-1 history bits are stored;
  // win is the full K-bit register content after the step.
  logic [K-2:0] hist;
  logic [K-1:0] win;

  assign win = {b, hist};
  assign c_a = ^(win & G_A);
  assign c_b = ^(win & G_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (step) begin
      hist <= win[K-1:1];
    end
  end
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame controller: pulls info bits, appends K-1 zero tail bits, serialises coded pairs.
// Latency: bit accepted in cycle N gives its c_a in N+1; y_ready low stalls y and throttles in_ready.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int           LEN_W = 8,
  parameter logic [K-1:0] G_A   = G_A_DEF,
  parameter logic [K-1:0] G_B   = G_B_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_first,
  output logic             y_last,
  output logic             busy,
  output logic             done,
  output logic             len_err
);
  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       tail_cnt;
  logic [1:0]       pend;
  logic             pair_a, pair_b, pair_first, pair_last, first_pend;
  logic             c_a, c_b;
  logic             step_ok, beat, data_step, tail_step, step;
  logic             frame_go, last_beat;

  // A new pair may load once the buffer is empty or its final beat leaves this cycle.
  assign step_ok   = (pend == 2'd0) || ((pend == 2'd1) && y_ready);
  assign beat      = y_valid && y_ready;
  assign in_ready  = (state == DATA) && step_ok && !abort;
  assign data_step = in_valid && in_ready;
  assign tail_step = (state == TAIL) && step_ok && !abort;
  assign step      = data_step || tail_step;
  assign frame_go  = (state == IDLE) && start && (frame_len != '0) && !abort;
  assign last_beat = (state == FLUSH) && beat && (pend == 2'd1) && !abort;

  assign y_valid = (pend != 2'd0);
  assign y       = pend[1] ? pair_a : (pend[0] && pair_b);
  assign y_first = (pend == 2'd2) && pair_first;
  assign y_last  = (pend == 2'd1) && pair_last;
  assign busy    = (state != IDLE);

  conv_core #(.G_A(G_A), .G_B(G_B)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort || frame_go),
    .step  (step),
    .b     (data_step && in_bit),
    .c_a   (c_a),
    .c_b   (c_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (frame_go) state_nxt = DATA;
        DATA:    if (data_step && (cnt == LEN_W'(1))) state_nxt = TAIL;
        TAIL:    if (tail_step && (tail_cnt == 2'd1)) state_nxt = FLUSH;
        FLUSH:   if (last_beat) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      tail_cnt   <= '0;
      pend       <= '0;
      pair_a     <= 1'b0;
      pair_b     <= 1'b0;
      pair_first <= 1'b0;
      pair_last  <= 1'b0;
      first_pend <= 1'b0;
      done       <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      done    <= last_beat;
      len_err <= (state == IDLE) && start && (frame_len == '0) && !abort;

      if (frame_go) cnt <= frame_len;
      else if (data_step) cnt <= cnt - LEN_W'(1);

      if (data_step && (cnt == LEN_W'(1))) tail_cnt <= 2'(TAIL_LEN);
      else if (tail_step) tail_cnt <= tail_cnt - 2'd1;

      if (frame_go) first_pend <= 1'b1;
      else if (step || abort) first_pend <= 1'b0;

      if (abort) begin
        pend <= 2'd0;
      end else if (step) begin
        pend       <= 2'd2;
        pair_a     <= c_a;
        pair_b     <= c_b;
        pair_first <= first_pend;
        pair_last  <= tail_step && (tail_cnt == 2'd1);
      end else if (beat) begin
        pend <= pend - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: table of frames with hand-derived coded streams checked via a scoreboard,
// plus length-error, abort and mid-frame reset sequences.
module tb_conv_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic       abort = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       y, y_valid, y_first, y_last, busy, done, len_err;
  logic       y_ready = 1'b0;

  typedef struct {
    string bits;
    int    mode;   // 0 always ready, 1 toggle, 2 random, 3 never
    int    gap;
    string exp_y;
  } vec_t;

  typedef struct {
    logic y;
    logic first;
    logic last;
    int   idx;
  } exp_t;

  vec_t tbl[6];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   rdy_mode = 0;
  logic mon_chk = 1'b1;

  conv_frame_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .abort(abort),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_first(y_first), .y_last(y_last),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // y_ready pattern generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       y_ready = 1'b1;
        1:       y_ready = ~y_ready;
        2:       y_ready = 1'($urandom_range(0, 1));
        default: y_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic stall_q = 1'b0;
    logic stall_y = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (mon_chk) begin
        if (stall_q) begin
          chk("stall_valid", int'(y_valid), 1);
          chk("stall_y", int'(y), int'(stall_y));
        end
        if (y_valid && exp_q.size() > 0 && exp_q[0].idx % 2 == 0)
          chk("in_ready_pend2", int'(in_ready), 0);
        if (y_valid && y_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("y[%0d]", e.idx), int'(y), int'(e.y));
            chk($sformatf("y_first[%0d]", e.idx), int'(y_first), int'(e.first));
            chk($sformatf("y_last[%0d]", e.idx), int'(y_last), int'(e.last));
          end
        end
      end
      stall_q = mon_chk && y_valid && !y_ready;
      stall_y = y;
    end
  end

  task automatic pulse_start(input int len);
    @(posedge clk);
    #1;
    start = 1'b1;
    frame_len = 8'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input string bits, input int nbits, input int gap);
    for (int j = 0; j < nbits; j++) begin
      int t;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_bit = (bits[j] == "1");
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 200) begin
          chk("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int i);
    int d0, t, n;
    n = tbl[i].exp_y.len();
    for (int j = 0; j < n; j++)
      exp_q.push_back('{y: (tbl[i].exp_y[j] == "1"), first: (j == 0), last: (j == n - 1), idx: j});
    rdy_mode = tbl[i].mode;
    d0 = done_cnt;
    pulse_start(tbl[i].bits.len());
    feed(tbl[i].bits, tbl[i].bits.len(), tbl[i].gap);
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) chk($sformatf("done_timeout_f%0d", i), 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk($sformatf("done_once_f%0d", i), done_cnt - d0, 1);
    chk($sformatf("busy_after_f%0d", i), int'(busy), 0);
    chk($sformatf("beats_left_f%0d", i), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int d0, lerr_n, busy_n, yv_n;

    tbl[0] = '{bits: "1011", mode: 0, gap: 0, exp_y: "110100101011"};
    tbl[1] = '{bits: "1011", mode: 1, gap: 0, exp_y: "110100101011"};
    tbl[2] = '{bits: "1011", mode: 0, gap: 3, exp_y: "110100101011"};
    tbl[3] = '{bits: "1",    mode: 0, gap: 0, exp_y: "110111"};
    tbl[4] = '{bits: "000",  mode: 2, gap: 1, exp_y: "0000000000"};
    tbl[5] = '{bits: "11",   mode: 1, gap: 2, exp_y: "11101011"};

    repeat (2) @(posedge clk);
    #3;
    chk("reset_outputs", int'({in_ready, y, y_valid, y_first, y_last, busy, done, len_err}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(i);

    // Zero-length start
    pulse_start(0);
    lerr_n = 0; busy_n = 0; yv_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lerr_n += int'(len_err);
      busy_n += int'(busy);
      yv_n   += int'(y_valid);
    end
    chk("len_err_pulses", lerr_n, 1);
    chk("len_err_busy", busy_n, 0);
    chk("len_err_y_valid", yv_n, 0);

    // Abort after two of four bits, then a fresh one-bit frame
    mon_chk = 1'b0;
    rdy_mode = 0;
    d0 = done_cnt;
    pulse_start(4);
    feed("1011", 2, 0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_y_valid", int'(y_valid), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    mon_chk = 1'b1;
    run_frame(3);

    // Reset while stalled in the tail
    mon_chk = 1'b0;
    rdy_mode = 0;
    pulse_start(4);
    feed("1011", 4, 0);
    rdy_mode = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("tail_busy_before_reset", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", int'({in_ready, y, y_valid, y_first, y_last, busy, done, len_err}), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    mon_chk = 1'b1;
    run_frame(0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "global timeout");
  end
endmodule
